alu_operand_issue: RTL

- Initiator side of the ALU operand interface. Sits between decode and the ALU in the pipelined MIPS core.
- Accepts decoded instructions over a valid/ready handshake and reads source registers. Resolves operands by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards and inserts bubbles. Drives registered op/a/b/imm to the ALU, and drops wrong-path work on a branch flush.

---
 rtl/alu_operand_issue_if.sv | 26 ++
 rtl/alu_operand_issue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue_if.sv
// ALU operand bus between the issue stage (master) and the ALU (slave).
// The issue stage drives the registered operands; the ALU returns alu_ready.
interface alu_operand_issue_if #(
   parameter int DSIZE  = 16,
   parameter int AWIDTH = 4
);
   logic              alu_valid;
   logic              alu_ready;
   logic [3:0]        alu_op;
   logic [DSIZE-1:0]  alu_a;
   logic [DSIZE-1:0]  alu_b;
   logic [DSIZE-1:0]  alu_imm;
   logic [AWIDTH-1:0] alu_rd;
   logic              alu_wen;
   logic [DSIZE-1:0]  alu_store_data;

   modport master (
      output alu_valid, alu_op, alu_a, alu_b, alu_imm, alu_rd, alu_wen, alu_store_data,
      input  alu_ready
   );

   modport slave (
      input  alu_valid, alu_op, alu_a, alu_b, alu_imm, alu_rd, alu_wen, alu_store_data,
      output alu_ready
   );
endinterface

// File: rtl/alu_operand_issue.sv
// Operand issue stage: forwarding, load-use bubble insertion and flush for the ALU.
// Optional ISSUE_PERF_CNT_EN adds saturating stall/flush counters.
module alu_operand_issue #(
   parameter int DSIZE  = 16,
   parameter int AWIDTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [AWIDTH-1:0] in_rs,
   input  logic [AWIDTH-1:0] in_rt,
   input  logic [AWIDTH-1:0] in_rd,
   input  logic              in_wen,
   input  logic [15:0]       in_imm,
   output logic [AWIDTH-1:0] rf_raddr1,
   output logic [AWIDTH-1:0] rf_raddr2,
   input  logic [DSIZE-1:0]  rf_rdata1,
   input  logic [DSIZE-1:0]  rf_rdata2,
   input  logic              exmem_wen,
   input  logic [AWIDTH-1:0] exmem_waddr,
   input  logic [DSIZE-1:0]  exmem_data,
   input  logic              memwb_wen,
   input  logic [AWIDTH-1:0] memwb_waddr,
   input  logic [DSIZE-1:0]  memwb_data,
   input  logic              flush,
   alu_operand_issue_if.master alu
`ifdef ISSUE_PERF_CNT_EN
   ,
   output logic [15:0]       perf_stall_cnt,
   output logic [15:0]       perf_flush_cnt
`endif
);

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_XOR = 4'd3;
   localparam logic [3:0] OP_SLL = 4'd4;
   localparam logic [3:0] OP_SRL = 4'd5;
   localparam logic [3:0] OP_COM = 4'd6;
   localparam logic [3:0] OP_MUL = 4'd7;
   localparam logic [3:0] OP_LW  = 4'd8;
   localparam logic [3:0] OP_SW  = 4'd9;
   localparam logic [3:0] OP_BEQ = 4'd10;

   typedef enum logic {RUN, STALL} state_t;

   state_t           state_q, state_d;
   logic             b_uses_rt, uses_rt;
   logic             hazard, can_load, accept;
   logic [DSIZE-1:0] fwd_a, fwd_b;
   logic [DSIZE-1:0] b_d, imm_d, sd_d;

   // EX/MEM is younger than MEM/WB, so it wins when both target the same register
   function automatic logic [DSIZE-1:0] fwd(
      input logic [AWIDTH-1:0] s,
      input logic [DSIZE-1:0]  rf,
      input logic              ex_wen,
      input logic [AWIDTH-1:0] ex_addr,
      input logic [DSIZE-1:0]  ex_data,
      input logic              wb_wen,
      input logic [AWIDTH-1:0] wb_addr,
      input logic [DSIZE-1:0]  wb_data
   );
      if (s == '0)                       return '0;
      else if (ex_wen && ex_addr == s)   return ex_data;
      else if (wb_wen && wb_addr == s)   return wb_data;
      else                               return rf;
   endfunction

   assign rf_raddr1 = in_rs;
   assign rf_raddr2 = in_rt;

   always_comb begin
      b_uses_rt = 1'b0;
      case (in_op)
         OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM, OP_MUL, OP_BEQ: b_uses_rt = 1'b1;
         default:                                                b_uses_rt = 1'b0;
      endcase
   end

   assign uses_rt = b_uses_rt || (in_op == OP_SW);

   assign fwd_a = fwd(in_rs, rf_rdata1, exmem_wen, exmem_waddr, exmem_data,
                      memwb_wen, memwb_waddr, memwb_data);
   assign fwd_b = fwd(in_rt, rf_rdata2, exmem_wen, exmem_waddr, exmem_data,
                      memwb_wen, memwb_waddr, memwb_data);

   // Once in STALL the load has left the issue register, so no further hazard is raised
   assign hazard = (state_q == RUN) && alu.alu_valid && (alu.alu_op == OP_LW) &&
                   alu.alu_wen && (alu.alu_rd != '0) &&
                   ((alu.alu_rd == in_rs) || (uses_rt && (alu.alu_rd == in_rt)));

   assign can_load = !alu.alu_valid || alu.alu_ready;
   assign in_ready = !rst && !flush && !hazard && can_load;
   assign accept   = in_valid && in_ready;

   always_comb begin
      b_d   = '0;
      imm_d = '0;
      sd_d  = '0;
      if (b_uses_rt) b_d = fwd_b;
      if (in_op == OP_SW) sd_d = fwd_b;
      case (in_op)
         OP_LW, OP_SW:   imm_d = DSIZE'($signed(in_imm));
         OP_SLL, OP_SRL: imm_d = DSIZE'(in_imm[3:0]);
         default:        imm_d = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (!flush && in_valid && hazard && can_load) state_d = STALL;
         STALL:   if (flush || accept) state_d = RUN;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu.alu_valid      <= 1'b0;
         alu.alu_op         <= '0;
         alu.alu_a          <= '0;
         alu.alu_b          <= '0;
         alu.alu_imm        <= '0;
         alu.alu_rd         <= '0;
         alu.alu_wen        <= 1'b0;
         alu.alu_store_data <= '0;
      end else if (flush) begin
         alu.alu_valid <= 1'b0;
      end else if (accept) begin
         alu.alu_valid      <= 1'b1;
         alu.alu_op         <= in_op;
         alu.alu_a          <= fwd_a;
         alu.alu_b          <= b_d;
         alu.alu_imm        <= imm_d;
         alu.alu_rd         <= in_rd;
         alu.alu_wen        <= in_wen;
         alu.alu_store_data <= sd_d;
      end else if (can_load) begin
         // consumed with nothing to replace it: bubble
         alu.alu_valid <= 1'b0;
      end
   end

`ifdef ISSUE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (in_valid && !in_ready && !flush && perf_stall_cnt != 16'hFFFF)
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         if (flush && alu.alu_valid && perf_flush_cnt != 16'hFFFF)
            perf_flush_cnt <= perf_flush_cnt + 16'd1;
      end
   end
`endif

endmodule
